// File: rtl/regfile_writer.sv
// Register-file write queue: buffers write requests in a small circular FIFO,
// drains one per cycle to the write port, and flags reads of pending registers.
module regfile_writer #(
  parameter int DEPTH = 4
) (
  input  logic                     Clk,
  input  logic                     Clr,
  input  logic                     In_Valid,
  output logic                     In_Ready,
  input  logic [4:0]               In_Wr,
  input  logic [31:0]              In_D,
  input  logic                     Hold,
  output logic [4:0]               Wr,
  output logic [31:0]              D,
  output logic                     We,
  input  logic [4:0]               Ra,
  input  logic [4:0]               Rb,
  output logic                     PendA,
  output logic                     PendB,
  output logic [$clog2(DEPTH):0]   Count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [4:0]    wr_mem [DEPTH];
  logic [31:0]   d_mem  [DEPTH];

  logic [AW-1:0] rd_ptr_reg, rd_ptr_next;
  logic [AW-1:0] wr_ptr_reg, wr_ptr_next;
  logic [CW-1:0] count_reg, count_next;
  logic          push, pop, not_empty;
  logic [DEPTH-1:0] hit_a, hit_b;

  assign not_empty = (count_reg != '0);
  assign In_Ready  = (count_reg < CW'(DEPTH));
  // Writes to R0 are accepted (handshake completes) but never stored.
  assign push      = In_Valid & In_Ready & (In_Wr != 5'd0);
  assign We        = not_empty & ~Hold;
  assign pop       = We;
  assign Wr        = not_empty ? wr_mem[rd_ptr_reg] : 5'd0;
  assign D         = not_empty ? d_mem[rd_ptr_reg]  : 32'd0;
  assign Count     = count_reg;

  always_comb begin
    rd_ptr_next = rd_ptr_reg;
    wr_ptr_next = wr_ptr_reg;
    count_next  = count_reg;
    if (pop)  rd_ptr_next = rd_ptr_reg + AW'(1);
    if (push) wr_ptr_next = wr_ptr_reg + AW'(1);
    case ({push, pop})
      2'b10:   count_next = count_reg + CW'(1);
      2'b01:   count_next = count_reg - CW'(1);
      default: count_next = count_reg;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Clr) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      rd_ptr_reg <= rd_ptr_next;
      wr_ptr_reg <= wr_ptr_next;
      count_reg  <= count_next;
    end
  end

  // Storage is left uncleared; validity comes purely from pointers and count.
  always_ff @(posedge Clk) begin
    if (push) begin
      wr_mem[wr_ptr_reg] <= In_Wr;
      d_mem[wr_ptr_reg]  <= In_D;
    end
  end

  // An entry is live when its distance from the head is below the count.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    logic [AW-1:0] age;
    logic          live;
    assign age       = AW'(gi) - rd_ptr_reg;
    assign live      = ({1'b0, age} < count_reg);
    assign hit_a[gi] = live & (wr_mem[gi] == Ra);
    assign hit_b[gi] = live & (wr_mem[gi] == Rb);
  end

  assign PendA = (Ra != 5'd0) & (|hit_a);
  assign PendB = (Rb != 5'd0) & (|hit_b);

endmodule

// File: tb/tb_regfile_writer.sv
// Self-checking bench for regfile_writer: directed scenarios plus a random
// run compared against a queue-based reference model.
module tb_regfile_writer;

  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          clr, in_valid, hold;
  logic [4:0]    in_wr, ra, rb;
  logic [31:0]   in_d;
  logic          in_ready, we, penda, pendb;
  logic [4:0]    wr;
  logic [31:0]   d;
  logic [CW-1:0] count;

  int n_total = 0;
  int n_pass  = 0;

  typedef struct packed {
    logic [4:0]  r;
    logic [31:0] d;
  } entry_t;
  entry_t q[$];

  regfile_writer #(.DEPTH(DEPTH)) dut (
    .Clk(clk), .Clr(clr), .In_Valid(in_valid), .In_Ready(in_ready),
    .In_Wr(in_wr), .In_D(in_d), .Hold(hold), .Wr(wr), .D(d), .We(we),
    .Ra(ra), .Rb(rb), .PendA(penda), .PendB(pendb), .Count(count)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic logic m_we();
    return (q.size() != 0) && !hold;
  endfunction

  function automatic logic [4:0] m_wr();
    return (q.size() != 0) ? q[0].r : 5'd0;
  endfunction

  function automatic logic [31:0] m_d();
    return (q.size() != 0) ? q[0].d : 32'd0;
  endfunction

  function automatic logic m_pend(input logic [4:0] r);
    if (r == 5'd0) return 1'b0;
    foreach (q[i]) if (q[i].r == r) return 1'b1;
    return 1'b0;
  endfunction

  // Apply inputs at the falling edge and let combinational outputs settle.
  task automatic set_inputs(input logic v, input logic [4:0] w, input logic [31:0] dd,
                            input logic h, input logic [4:0] a, input logic [4:0] b,
                            input logic c);
    @(negedge clk);
    in_valid = v; in_wr = w; in_d = dd; hold = h; ra = a; rb = b; clr = c;
    #1;
  endtask

  // Advance one rising edge and update the model with the same inputs.
  task automatic tick();
    logic acc;
    @(posedge clk);
    if (clr) begin
      q.delete();
    end else begin
      acc = in_valid && (q.size() < DEPTH);
      if ((q.size() != 0) && !hold) void'(q.pop_front());
      if (acc && in_wr != 5'd0) q.push_back('{r: in_wr, d: in_d});
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    set_inputs(1'b1, 5'd3, 32'h1, 1'b0, 5'd0, 5'd0, 1'b1);
    tick();
    set_inputs(1'b0, 5'd0, 32'h0, 1'b0, 5'd3, 5'd3, 1'b0);
    n_total++; if (count !== '0)    $display("FAIL reset_count got %0d want 0", count); else n_pass++;
    n_total++; if (we !== 1'b0)     $display("FAIL reset_we got %0b want 0", we); else n_pass++;
    n_total++; if (wr !== 5'd0)     $display("FAIL reset_wr got %0d want 0", wr); else n_pass++;
    n_total++; if (d !== 32'd0)     $display("FAIL reset_d got %h want 0", d); else n_pass++;
    n_total++; if (in_ready !== 1'b1) $display("FAIL reset_ready got %0b want 1", in_ready); else n_pass++;
    n_total++; if ({penda, pendb} !== 2'b00) $display("FAIL reset_pend got %b want 00", {penda, pendb}); else n_pass++;
    $display("reset: count=%0d we=%0b ready=%0b", count, we, in_ready);
  endtask

  task automatic test_single();
    set_inputs(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 5'd0, 1'b0);
    tick();
    set_inputs(1'b0, 5'd0, 32'h0, 1'b0, 5'd5, 5'd0, 1'b0);
    n_total++; if (we !== 1'b1)          $display("FAIL single_we got %0b want 1", we); else n_pass++;
    n_total++; if (wr !== 5'd5)          $display("FAIL single_wr got %0d want 5", wr); else n_pass++;
    n_total++; if (d !== 32'hDEADBEEF)   $display("FAIL single_d got %h want deadbeef", d); else n_pass++;
    n_total++; if (penda !== 1'b1)       $display("FAIL single_penda got %0b want 1", penda); else n_pass++;
    tick();
    set_inputs(1'b0, 5'd0, 32'h0, 1'b0, 5'd5, 5'd0, 1'b0);
    n_total++; if (we !== 1'b0)          $display("FAIL single_we_after got %0b want 0", we); else n_pass++;
    n_total++; if (count !== '0)         $display("FAIL single_count_after got %0d want 0", count); else n_pass++;
    n_total++; if (penda !== 1'b0)       $display("FAIL single_penda_after got %0b want 0", penda); else n_pass++;
    $display("single: wrote R5=deadbeef, count now %0d", count);
  endtask

  task automatic test_hold_fill();
    for (int i = 1; i <= 4; i++) begin
      set_inputs(1'b1, 5'(i), 32'(100 + i), 1'b1, 5'd0, 5'd0, 1'b0);
      n_total++; if (we !== 1'b0) $display("FAIL hold_we_%0d got %0b want 0", i, we); else n_pass++;
      tick();
    end
    set_inputs(1'b1, 5'd9, 32'h99, 1'b1, 5'd9, 5'd2, 1'b0);
    n_total++; if (count !== CW'(4))  $display("FAIL hold_full_count got %0d want 4", count); else n_pass++;
    n_total++; if (in_ready !== 1'b0) $display("FAIL hold_full_ready got %0b want 0", in_ready); else n_pass++;
    n_total++; if (wr !== 5'd1)       $display("FAIL hold_head_wr got %0d want 1", wr); else n_pass++;
    n_total++; if ({penda, pendb} !== 2'b01) $display("FAIL hold_pend got %b want 01", {penda, pendb}); else n_pass++;
    tick();
    for (int i = 1; i <= 4; i++) begin
      set_inputs(1'b0, 5'd0, 32'h0, 1'b0, 5'd9, 5'd0, 1'b0);
      n_total++; if (we !== 1'b1)        $display("FAIL drain_we_%0d got %0b want 1", i, we); else n_pass++;
      n_total++; if (wr !== 5'(i))       $display("FAIL drain_wr_%0d got %0d want %0d", i, wr, i); else n_pass++;
      n_total++; if (d !== 32'(100 + i)) $display("FAIL drain_d_%0d got %0d want %0d", i, d, 100 + i); else n_pass++;
      n_total++; if (penda !== 1'b0)     $display("FAIL drain_r9_pend_%0d got %0b want 0", i, penda); else n_pass++;
      $display("drain: R%0d=%0d", wr, d);
      tick();
    end
    set_inputs(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 1'b0);
    n_total++; if (we !== 1'b0) $display("FAIL drain_done_we got %0b want 0", we); else n_pass++;
  endtask

  task automatic test_r0();
    set_inputs(1'b1, 5'd0, 32'h12345678, 1'b0, 5'd0, 5'd0, 1'b0);
    n_total++; if (in_ready !== 1'b1) $display("FAIL r0_ready got %0b want 1", in_ready); else n_pass++;
    tick();
    for (int i = 0; i < 2; i++) begin
      set_inputs(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 1'b0);
      n_total++; if (count !== '0)   $display("FAIL r0_count_%0d got %0d want 0", i, count); else n_pass++;
      n_total++; if (we !== 1'b0)    $display("FAIL r0_we_%0d got %0b want 0", i, we); else n_pass++;
      n_total++; if (penda !== 1'b0) $display("FAIL r0_penda_%0d got %0b want 0", i, penda); else n_pass++;
      tick();
    end
    $display("r0: request discarded, count=%0d", count);
  endtask

  task automatic test_stream();
    logic [4:0]  sr [10];
    logic [31:0] sd [10];
    for (int k = 0; k < 10; k++) begin
      sr[k] = 5'($urandom_range(1, 31));
      sd[k] = $urandom;
    end
    for (int k = 0; k <= 10; k++) begin
      if (k < 10) set_inputs(1'b1, sr[k], sd[k], 1'b0, 5'd0, 5'd0, 1'b0);
      else        set_inputs(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 1'b0);
      if (k > 0) begin
        n_total++; if (count !== CW'(1))  $display("FAIL stream_count_%0d got %0d want 1", k, count); else n_pass++;
        n_total++; if (we !== 1'b1)       $display("FAIL stream_we_%0d got %0b want 1", k, we); else n_pass++;
        n_total++; if (wr !== sr[k-1])    $display("FAIL stream_wr_%0d got %0d want %0d", k, wr, sr[k-1]); else n_pass++;
        n_total++; if (d !== sd[k-1])     $display("FAIL stream_d_%0d got %h want %h", k, d, sd[k-1]); else n_pass++;
        $display("stream %0d: R%0d=%h", k - 1, wr, d);
      end
      tick();
    end
    set_inputs(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 1'b0);
    n_total++; if (count !== '0) $display("FAIL stream_end_count got %0d want 0", count); else n_pass++;
  endtask

  task automatic test_same_reg();
    set_inputs(1'b1, 5'd7, 32'h1, 1'b1, 5'd0, 5'd7, 1'b0);
    tick();
    set_inputs(1'b1, 5'd7, 32'h2, 1'b1, 5'd0, 5'd7, 1'b0);
    n_total++; if (pendb !== 1'b1) $display("FAIL same_pendb_held got %0b want 1", pendb); else n_pass++;
    tick();
    set_inputs(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd7, 1'b0);
    n_total++; if (we !== 1'b1 || wr !== 5'd7 || d !== 32'h1)
      $display("FAIL same_first got we=%0b R%0d=%h want we=1 R7=1", we, wr, d); else n_pass++;
    n_total++; if (pendb !== 1'b1) $display("FAIL same_pendb_1 got %0b want 1", pendb); else n_pass++;
    tick();
    set_inputs(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd7, 1'b0);
    n_total++; if (we !== 1'b1 || wr !== 5'd7 || d !== 32'h2)
      $display("FAIL same_second got we=%0b R%0d=%h want we=1 R7=2", we, wr, d); else n_pass++;
    n_total++; if (pendb !== 1'b1) $display("FAIL same_pendb_2 got %0b want 1", pendb); else n_pass++;
    tick();
    set_inputs(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd7, 1'b0);
    n_total++; if (pendb !== 1'b0) $display("FAIL same_pendb_done got %0b want 0", pendb); else n_pass++;
    n_total++; if (we !== 1'b0)    $display("FAIL same_we_done got %0b want 0", we); else n_pass++;
    $display("same_reg: R7 written 1 then 2");
  endtask

  task automatic test_clr_mid();
    for (int i = 0; i < 3; i++) begin
      set_inputs(1'b1, 5'(10 + i), 32'(i), 1'b1, 5'd0, 5'd0, 1'b0);
      tick();
    end
    set_inputs(1'b1, 5'd13, 32'h33, 1'b0, 5'd10, 5'd12, 1'b1);
    n_total++; if (count !== CW'(3)) $display("FAIL clr_pre_count got %0d want 3", count); else n_pass++;
    tick();
    for (int i = 0; i < 2; i++) begin
      set_inputs(1'b0, 5'd0, 32'h0, 1'b0, 5'd10, 5'd13, 1'b0);
      n_total++; if (count !== '0)      $display("FAIL clr_count_%0d got %0d want 0", i, count); else n_pass++;
      n_total++; if (we !== 1'b0)       $display("FAIL clr_we_%0d got %0b want 0", i, we); else n_pass++;
      n_total++; if (in_ready !== 1'b1) $display("FAIL clr_ready_%0d got %0b want 1", i, in_ready); else n_pass++;
      n_total++; if ({penda, pendb} !== 2'b00) $display("FAIL clr_pend_%0d got %b want 00", i, {penda, pendb}); else n_pass++;
      tick();
    end
    $display("clr_mid: queue flushed, count=%0d", count);
  endtask

  task automatic test_random();
    logic v, h, c;
    for (int n = 0; n < 300; n++) begin
      v = ($urandom_range(0, 9) < 7);
      h = ($urandom_range(0, 9) < 3);
      c = ($urandom_range(0, 49) == 0);
      set_inputs(v, 5'($urandom_range(0, 7)), $urandom, h,
                 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), c);
      n_total++; if (in_ready !== (q.size() < DEPTH)) $display("FAIL rnd_ready_%0d got %0b want %0b", n, in_ready, q.size() < DEPTH); else n_pass++;
      n_total++; if (count !== CW'(q.size())) $display("FAIL rnd_count_%0d got %0d want %0d", n, count, q.size()); else n_pass++;
      n_total++; if (we !== m_we())           $display("FAIL rnd_we_%0d got %0b want %0b", n, we, m_we()); else n_pass++;
      n_total++; if (wr !== m_wr())           $display("FAIL rnd_wr_%0d got %0d want %0d", n, wr, m_wr()); else n_pass++;
      n_total++; if (d !== m_d())             $display("FAIL rnd_d_%0d got %h want %h", n, d, m_d()); else n_pass++;
      n_total++; if (penda !== m_pend(ra))    $display("FAIL rnd_penda_%0d got %0b want %0b", n, penda, m_pend(ra)); else n_pass++;
      n_total++; if (pendb !== m_pend(rb))    $display("FAIL rnd_pendb_%0d got %0b want %0b", n, pendb, m_pend(rb)); else n_pass++;
      if (we) $display("rnd %0d: write R%0d=%h count=%0d", n, wr, d, count);
      tick();
    end
  endtask

  initial begin
    clr = 1'b1; in_valid = 1'b0; in_wr = '0; in_d = '0; hold = 1'b0; ra = '0; rb = '0;
    test_reset();
    test_single();
    test_hold_fill();
    test_r0();
    test_stream();
    test_same_reg();
    test_clr_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/regfile_writer.md
REGFILE_WRITER -- requirements
Module: regfile_writer

Interface
REQ-001 SHALL have parameter DEPTH, default 4, queue entries (power of two, >=2).
REQ-002 SHALL have port Clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port Clr  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port In_Valid  input  1  write request present.
REQ-005 SHALL have port In_Ready  output  1  queue can accept a request this cycle.
REQ-006 SHALL have port In_Wr  input  5  destination register number.
REQ-007 SHALL have port In_D  input  32  write data.
REQ-008 SHALL have port Hold  input  1  register file write port unavailable; suspend draining.
REQ-009 SHALL have port Wr  output  5  register number to the register file write port.
REQ-010 SHALL have port D  output  32  data to the register file write port.
REQ-011 SHALL have port We  output  1  write enable to the register file write port.
REQ-012 SHALL have ports Ra, Rb  input  5 each  registers being read by decode.
REQ-013 SHALL have ports PendA, PendB  output  1 each  queued write pending to Ra / Rb.
REQ-014 SHALL have port Count  output  log2(DEPTH)+1  number of valid queue entries.

Function
REQ-015 SHALL hold requests in a DEPTH-entry circular FIFO with read/write pointers wrapping modulo DEPTH.
REQ-016 SHALL drive In_Ready = (Count < DEPTH), from registered state only, independent of Hold and In_Valid.
REQ-017 SHALL accept a request on a rising edge where In_Valid=1 and In_Ready=1; In_Wr/In_D are sampled at that edge.
REQ-018 SHALL discard accepted requests with In_Wr=0 (R0 hardwired zero): no enqueue, no Count change.
REQ-019 SHALL drive We = (Count!=0) & ~Hold combinationally, and Wr/D = head entry's register number/data.
REQ-020 SHALL pop the head on every rising edge where We=1; an entry accepted at edge N reaches the register file at edge N+1 at the earliest.
REQ-021 SHALL, on simultaneous accept and pop, enqueue and dequeue in the same edge with Count unchanged.
REQ-022 SHALL drive Wr=0, D=0 when Count=0.
REQ-023 SHALL preserve FIFO order; multiple entries to the same register are all written, oldest first.
REQ-024 SHALL drive PendA=1 iff Ra!=0 and any valid entry (head included, Hold irrelevant) has register number Ra; PendB likewise for Rb; combinational.
REQ-025 SHALL, while Hold=1, keep accepting until full and keep the head stable on Wr/D.
REQ-026 SHALL never overflow or underflow; Count ranges 0..DEPTH.

Reset
REQ-027 SHALL, on a rising edge with Clr=1, set Count=0 and both pointers to 0; entry storage need not be cleared.
REQ-028 SHALL give reset priority over a simultaneous accept or pop: the request is dropped, no entry survives.
REQ-029 SHALL, in the cycle after reset, present We=0, Wr=0, D=0, In_Ready=1, PendA=PendB=0, Count=0.
REQ-030 SHALL, on reset mid-operation, not assert We again until a new request is accepted.

Verification
REQ-031 SHALL cover: single request In_Wr=5, In_D=0xDEADBEEF, Hold=0 -> next cycle We=1, Wr=5, D=0xDEADBEEF, PendA=1 with Ra=5; following cycle We=0, Count=0.
REQ-032 SHALL cover: Hold=1, requests to R1..R4 on four consecutive cycles -> Count=4, In_Ready=0, fifth request not accepted; Hold=0 -> We=1 for 4 cycles writing R1,R2,R3,R4 in order.
REQ-033 SHALL cover: request In_Wr=0, In_D=0x12345678 -> In_Ready=1, Count stays 0, We never asserted, PendA=0 with Ra=0.
REQ-034 SHALL cover: steady stream one request per cycle, Hold=0 -> Count stays 1, We=1 every cycle, data written in order; pointers wrap past DEPTH-1 with no loss over 10 requests.
REQ-035 SHALL cover: two queued writes to R7 (0x1, then 0x2) under Hold, then release -> writes 0x1 then 0x2; PendB=1 (Rb=7) until the second write's edge, then 0.
REQ-036 SHALL cover: Count=3, Clr=1 with In_Valid=1 same edge -> next cycle Count=0, We=0, In_Ready=1, PendA=PendB=0.
